// File: rtl/decode_stage.sv
// Decode stage: decodes a raw RV instruction and buffers the result in a small
// in-order queue (DEPTH entries) so the consumer always sees registered outputs.
// Optional macro DECODE_RV64W_EN adds ADDIW/ADDW word-op decode (XLEN=64 only)
// and the out_word output.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_op,
  output logic [3:0]      out_alufunc,
  output logic            out_regwrite,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
`ifdef DECODE_RV64W_EN
  ,
  output logic            out_word
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [4:0] {
    OP_UNKNOWN = 5'd0,
    OP_ADDI    = 5'd1,
    OP_XORI    = 5'd2,
    OP_ORI     = 5'd3,
    OP_ANDI    = 5'd4,
    OP_ADD     = 5'd5,
    OP_SUB     = 5'd6,
    OP_LUI     = 5'd7,
    OP_ADDIW   = 5'd8,
    OP_ADDW    = 5'd9
  } op_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_PASSB = 4'd5
  } alu_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    op_e             op;
    alu_e            alu;
    logic            regwrite;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
`ifdef DECODE_RV64W_EN
    logic            word;
`endif
  } entry_t;

  entry_t           dec;
  logic             legal;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Combinational decode of the incoming word; illegal encodings collapse to zeros
  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    dec.pc     = in_pc;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    case (opcode)
      7'b0010011: begin
        dec.imm = XLEN'($signed(in_instr[31:20]));
        case (funct3)
          3'b000:  begin dec.op = OP_ADDI; dec.alu = ALU_ADD; end
          3'b100:  begin dec.op = OP_XORI; dec.alu = ALU_XOR; end
          3'b110:  begin dec.op = OP_ORI;  dec.alu = ALU_OR;  end
          3'b111:  begin dec.op = OP_ANDI; dec.alu = ALU_AND; end
          default: legal = 1'b0;
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
          dec.op  = OP_ADD;
          dec.alu = ALU_ADD;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.op  = OP_SUB;
          dec.alu = ALU_SUB;
        end else begin
          legal = 1'b0;
        end
      end
      7'b0110111: begin
        dec.op  = OP_LUI;
        dec.alu = ALU_PASSB;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
`ifdef DECODE_RV64W_EN
      7'b0011011: begin
        if (XLEN == 64 && funct3 == 3'b000) begin
          dec.op   = OP_ADDIW;
          dec.alu  = ALU_ADD;
          dec.imm  = XLEN'($signed(in_instr[31:20]));
          dec.word = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      7'b0111011: begin
        if (XLEN == 64 && funct7 == 7'b0000000 && funct3 == 3'b000) begin
          dec.op   = OP_ADDW;
          dec.alu  = ALU_ADD;
          dec.word = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.op  = OP_UNKNOWN;
      dec.alu = ALU_ADD;
      dec.imm = '0;
    end
    dec.illegal  = ~legal;
    dec.regwrite = legal & (in_instr[11:7] != 5'd0);
  end

  // Queue pointers and occupancy; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage is deliberately not reset; occupancy alone says what is valid
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= dec;
  end

  assign out_pc       = mem[head_ptr].pc;
  assign out_op       = mem[head_ptr].op;
  assign out_alufunc  = mem[head_ptr].alu;
  assign out_regwrite = mem[head_ptr].regwrite;
  assign out_rd       = mem[head_ptr].rd;
  assign out_rs1      = mem[head_ptr].rs1;
  assign out_rs2      = mem[head_ptr].rs2;
  assign out_imm      = mem[head_ptr].imm;
  assign out_illegal  = mem[head_ptr].illegal;
`ifdef DECODE_RV64W_EN
  assign out_word     = mem[head_ptr].word;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus randomized traffic, all
// checked against a queue-based behavioural model. Honours DECODE_RV64W_EN.
module tb_decode_stage;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_op;
  logic [3:0]      out_alufunc;
  logic            out_regwrite;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
`ifdef DECODE_RV64W_EN
  logic            out_word;
`endif

  int tests_run = 0;
  int failures  = 0;
  bit checking  = 0;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_alufunc(out_alufunc), .out_regwrite(out_regwrite),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_illegal(out_illegal)
`ifdef DECODE_RV64W_EN
    , .out_word(out_word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  op;
    logic [3:0]  alu;
    logic        regwrite;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        illegal;
    logic        word;
  } exp_t;

  exp_t mq[$];
  bit   m_pop;
  bit   m_push;

  // Reference decode from the ISA table: match (funct7, funct3, opcode) patterns
  function automatic exp_t ref_decode(logic [31:0] ins, logic [63:0] pc);
    exp_t        e;
    longint      v;
    bit          legal;
    bit          imm_i;
    logic [16:0] key;
    e       = '0;
    e.pc    = pc;
    e.rd    = ins[11:7];
    e.rs1   = ins[19:15];
    e.rs2   = ins[24:20];
    legal   = 1;
    imm_i   = 0;
    v       = 0;
    key     = {ins[31:25], ins[14:12], ins[6:0]};
    casez (key)
      17'b???????_000_0010011: begin e.op = 1; e.alu = 0; imm_i = 1; end
      17'b???????_100_0010011: begin e.op = 2; e.alu = 2; imm_i = 1; end
      17'b???????_110_0010011: begin e.op = 3; e.alu = 3; imm_i = 1; end
      17'b???????_111_0010011: begin e.op = 4; e.alu = 4; imm_i = 1; end
      17'b0000000_000_0110011: begin e.op = 5; e.alu = 0; end
      17'b0100000_000_0110011: begin e.op = 6; e.alu = 1; end
      17'b???????_???_0110111: begin
        e.op = 7; e.alu = 5;
        v = longint'(ins[31:12]);
        if (v >= 524288) v = v - 1048576;
        v = v * 4096;
      end
`ifdef DECODE_RV64W_EN
      17'b???????_000_0011011: begin e.op = 8; e.alu = 0; imm_i = 1; e.word = 1; end
      17'b0000000_000_0111011: begin e.op = 9; e.alu = 0; e.word = 1; end
`endif
      default: legal = 0;
    endcase
    if (imm_i) begin
      v = longint'(ins[31:20]);
      if (v >= 2048) v = v - 4096;
    end
    e.imm      = legal ? 64'(v) : 64'd0;
    e.illegal  = !legal;
    e.regwrite = legal && (ins[11:7] != 5'd0);
    return e;
  endfunction

  // Model of the queue: reset/flush clear it, otherwise pop head and push decoded word
  always @(posedge clk) begin
    if (reset || flush) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = in_valid && (mq.size() < DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(ref_decode(in_instr, 64'(in_pc)));
    end
  end

  // Every cycle compare handshake flags and, when valid, the head entry
  always @(negedge clk) begin
    exp_t act;
    if (checking) begin
      tests_run++;
      if (out_valid !== (mq.size() != 0)) begin
        failures++;
        $display("[TB] FAIL out_valid: got %b expected %b", out_valid, mq.size() != 0);
      end
      tests_run++;
      if (in_ready !== (mq.size() < DEPTH)) begin
        failures++;
        $display("[TB] FAIL in_ready: got %b expected %b", in_ready, mq.size() < DEPTH);
      end
      if (mq.size() != 0) begin
        act.pc       = 64'(out_pc);
        act.op       = out_op;
        act.alu      = out_alufunc;
        act.regwrite = out_regwrite;
        act.rd       = out_rd;
        act.rs1      = out_rs1;
        act.rs2      = out_rs2;
        act.imm      = 64'(out_imm);
        act.illegal  = out_illegal;
`ifdef DECODE_RV64W_EN
        act.word     = out_word;
`else
        act.word     = 1'b0;
`endif
        tests_run++;
        if (act !== mq[0]) begin
          failures++;
          $display("[TB] FAIL head_entry: got %h expected %h", act, mq[0]);
        end
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                               input bit ordy, input bit fl, input bit rst);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc[XLEN-1:0];
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[6:0] = 7'b0010011;
      1: begin
        r[6:0] = 7'b0110011;
        if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
      end
      2: r[6:0] = 7'b0110111;
      3: r[6:0] = 7'b0011011;
      4: begin r[6:0] = 7'b0111011; r[31:25] = 7'b0000000; end
      5: begin r[6:0] = 7'b0110011; r[31:25] = 7'b0000000; r[14:12] = 3'b000; end
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) r[14:12] = 3'b000;
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  exp_t pin;

  initial begin
    in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 0; flush = 0; reset = 1;
    applyStimulus(0, 32'h0, 64'h0, 0, 0, 1);
    checking = 1;
    applyStimulus(0, 32'h0, 64'h0, 0, 0, 1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    // model pins against hand-decoded values
    pin = ref_decode(32'h402081B3, 64'h0);
    checkOutput("model_sub_op", 64'(pin.op), 64'd6);
    pin = ref_decode(32'h123452B7, 64'h0);
    checkOutput("model_lui_imm", pin.imm, 64'h0000000012345000);
    pin = ref_decode(32'hFFF00093, 64'h0);
    checkOutput("model_neg_imm", pin.imm, 64'hFFFFFFFFFFFFFFFF);

    // addi x1,x0,5
    applyStimulus(1, 32'h00500093, 64'h80000000, 1, 0, 0);
    checkOutput("addi_valid", 64'(out_valid), 64'd1);
    checkOutput("addi_op", 64'(out_op), 64'd1);
    checkOutput("addi_alu", 64'(out_alufunc), 64'd0);
    checkOutput("addi_rd", 64'(out_rd), 64'd1);
    checkOutput("addi_imm", 64'(out_imm), 64'd5);
    checkOutput("addi_regwrite", 64'(out_regwrite), 64'd1);
    checkOutput("addi_illegal", 64'(out_illegal), 64'd0);
    checkOutput("addi_pc", 64'(out_pc), 64'h80000000);

    // back-to-back addi -1 then sub x3,x1,x2
    applyStimulus(1, 32'hFFF00093, 64'h80000004, 1, 0, 0);
    checkOutput("neg_imm", 64'(out_imm), 64'hFFFFFFFFFFFFFFFF);
    checkOutput("neg_op", 64'(out_op), 64'd1);
    applyStimulus(1, 32'h402081B3, 64'h80000008, 1, 0, 0);
    checkOutput("sub_op", 64'(out_op), 64'd6);
    checkOutput("sub_alu", 64'(out_alufunc), 64'd1);
    checkOutput("sub_rd", 64'(out_rd), 64'd3);
    checkOutput("sub_rs1", 64'(out_rs1), 64'd1);
    checkOutput("sub_rs2", 64'(out_rs2), 64'd2);

    // lui x5 then addi x0
    applyStimulus(1, 32'h123452B7, 64'h8000000C, 1, 0, 0);
    checkOutput("lui_op", 64'(out_op), 64'd7);
    checkOutput("lui_alu", 64'(out_alufunc), 64'd5);
    checkOutput("lui_rd", 64'(out_rd), 64'd5);
    checkOutput("lui_imm", 64'(out_imm), 64'h0000000012345000);
    applyStimulus(1, 32'h00000013, 64'h80000010, 1, 0, 0);
    checkOutput("nop_regwrite", 64'(out_regwrite), 64'd0);
    checkOutput("nop_illegal", 64'(out_illegal), 64'd0);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);

    // fill with consumer stalled, then drain
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 32'h00000093 | (32'(i + 1) << 20), 64'h100 + 64'(4 * i), 0, 0, 0);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1, 32'h00700093, 64'h200, 0, 0, 0);
    checkOutput("full_head_pc", 64'(out_pc), 64'h100);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);
    checkOutput("after_pop_in_ready", 64'(in_ready), 64'd1);
    checkOutput("after_pop_head_pc", 64'(out_pc), 64'h104);
    for (int i = 1; i < DEPTH; i++) applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);
    checkOutput("drained_valid", 64'(out_valid), 64'd0);

    // flush with concurrent push
    applyStimulus(1, 32'h00100093, 64'h300, 0, 0, 0);
    applyStimulus(1, 32'h00200093, 64'h304, 0, 0, 0);
    applyStimulus(1, 32'h00300093, 64'h308, 1, 1, 0);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);

    // reset mid-stream, with flush also high
    applyStimulus(1, 32'h00100093, 64'h310, 0, 0, 0);
    applyStimulus(1, 32'h00200093, 64'h314, 0, 0, 0);
    applyStimulus(1, 32'h00300093, 64'h318, 1, 1, 1);
    checkOutput("reset_mid_valid", 64'(out_valid), 64'd0);

    // addiw x1,x1,1
    applyStimulus(1, 32'h0010809B, 64'h400, 1, 0, 0);
`ifdef DECODE_RV64W_EN
    checkOutput("addiw_op", 64'(out_op), 64'd8);
    checkOutput("addiw_word", 64'(out_word), 64'd1);
    checkOutput("addiw_imm", 64'(out_imm), 64'd1);
`else
    checkOutput("addiw_op", 64'(out_op), 64'd0);
    checkOutput("addiw_illegal", 64'(out_illegal), 64'd1);
    checkOutput("addiw_regwrite", 64'(out_regwrite), 64'd0);
`endif
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++)
      applyStimulus($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
                    $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                    $urandom_range(0, 127) == 0);

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
